// File: rtl/iccad_lane_pkg.sv
// rtl/iccad_lane_pkg.sv - shared constants, FSM state type and latency helper for iccad_lane_pipe
// Contents: MODE_FEEDBACK/MODE_BYPASS encodings, state_t {S_FILL, S_RUN}, lat(depth).
package iccad_lane_pkg;

  localparam logic MODE_FEEDBACK = 1'b0;
  localparam logic MODE_BYPASS   = 1'b1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Total enabled edges from input sample to output: feedback flop plus delay stages.
  function automatic int lat(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/iccad_delay_line.sv
// rtl/iccad_delay_line.sv - DEPTH-stage enabled, clearable registered delay line
// Ports: clock, reset (sync, active-high), enable (advance), clear (zero all stages
// when enabled), d (stage 0 input), q (last stage).
module iccad_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else if (enable) begin
      if (clear) begin
        for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      end else begin
        stg[0] <= d;
        for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
      end
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/iccad_lane_pipe.sv
// rtl/iccad_lane_pipe.sv - multi-lane NAND/NOR-feedback flop with delay line, fill tracking and mode flush
// Ports: iccad_clk, iccad_rst (sync, active-high), en (advance), mode (0 feedback,
// 1 bypass), inp1/inp2 (lane operands), out (last delay stage), out_valid (pipe full).
module iccad_lane_pipe
  import iccad_lane_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int            LAT   = lat(DEPTH);
  localparam int            CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] fq;
  logic [WIDTH-1:0] fq_next;
  logic             mode_q;
  logic             flush;
  logic [CW-1:0]    cnt;
  state_t           state;

  assign n1    = ~(inp1 & inp2);
  // A requested mode differing from the applied one flushes instead of sampling.
  assign flush = (mode != mode_q);

  always_comb begin
    fq_next = ~(n1 | fq);
    if (mode_q == MODE_BYPASS) fq_next = ~n1;
  end

  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) begin
      fq     <= '0;
      mode_q <= MODE_FEEDBACK;
      cnt    <= '0;
      state  <= S_FILL;
    end else if (en) begin
      if (flush) begin
        fq     <= '0;
        mode_q <= mode;
        cnt    <= '0;
        state  <= S_FILL;
      end else begin
        fq <= fq_next;
        if (cnt != LAT_C) cnt <= cnt + 1'b1;
        // Enter RUN exactly on the edge that brings the counter to LAT.
        if (cnt == LAT_C - 1'b1) state <= S_RUN;
      end
    end
  end

  iccad_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .clock  (iccad_clk),
    .reset  (iccad_rst),
    .enable (en),
    .clear  (flush),
    .d      (fq),
    .q      (out)
  );

  assign out_valid = (state == S_RUN) && (cnt == LAT_C);

endmodule

// File: doc/iccad_lane_pipe.md
# iccad_lane_pipe

Parametrised, multi-lane successor to the single-bit NAND/NOR-feedback flop cell used in our timing-parser test circuits. Each of `WIDTH` lanes computes a NAND of two inputs, feeds it through a NOR/feedback flop (or bypasses the feedback, selected at runtime), then through a `DEPTH`-stage registered delay line. An enable stalls the whole pipe, a fill counter drives `out_valid`, and a mode change flushes the pipe. The block sits between primary inputs and timing-critical outputs in generated benchmark designs, so it exercises the parser and timer on wider, deeper sequential paths.

## Interface
- `WIDTH`, 1, number of independent lanes (≥1)
- `DEPTH`, 2, delay-line stages after the feedback flop (≥1); total latency `LAT = DEPTH+1`
- `iccad_clk`  in  1  sole clock; all state updates on its rising edge
- `iccad_rst`  in  1  reset, synchronous, active-high
- `en`  in  1  advance enable; 0 freezes all state
- `mode`  in  1  0 = FEEDBACK, 1 = BYPASS
- `inp1`  in  WIDTH  lane operand A
- `inp2`  in  WIDTH  lane operand B
- `out`  out  WIDTH  last delay-stage value
- `out_valid`  out  1  `out` carries data sampled after the last reset/flush

## Operation
- Per lane i: `n1[i] = ~(inp1[i] & inp2[i])`.
- Feedback register `fq[i]` next value: FEEDBACK: `~(n1[i] | fq[i])` = `(inp1&inp2) & ~fq`; BYPASS: `~n1[i]` = `inp1&inp2`.
- Delay line: `stg[0] <= fq`, `stg[k] <= stg[k-1]`; `out = stg[DEPTH-1]`.
- `mode_q` holds the registered mode; the mode applied in the `fq` equation is `mode_q`.
- Fill counter `cnt`, width `$clog2(LAT+1)`, saturates at `LAT`; `out_valid = (cnt == LAT)`.
- Two-state FSM: FILL (cnt < LAT) → RUN on the enabled edge that makes cnt = LAT; RUN → FILL on flush or reset. Never RUN→RUN with cnt < LAT.
- Enabled edge (`en=1`, no reset):
  - if `mode != mode_q`: flush: `fq`, all `stg`, `cnt` ← 0; `mode_q` ← `mode`; state ← FILL. Input not sampled this edge.
  - else: `fq`, `stg` update as above; `cnt` ← min(cnt+1, LAT).
- Disabled edge (`en=0`): every register holds, including `mode_q`; a mode change while disabled is acted on at the next enabled edge.
- Reset: `fq`, `stg`, `cnt` ← 0; `mode_q` ← 0 (FEEDBACK); state FILL. `out` = 0, `out_valid` = 0 from the edge after `iccad_rst` is sampled high. Reset overrides `en` and mode change.

## Timing
- Latency: input sampled at enabled edge N appears on `out` after enabled edge N+DEPTH (LAT enabled edges total, counting N).
- `out_valid` rises after the LAT-th enabled edge following reset/flush and stays high until the next flush/reset.
- Flush: `out` and `out_valid` go 0 after the flushing edge; `out_valid` returns LAT enabled edges later.
- Stalls do not add or lose samples; latency is counted in enabled edges only.
- Outputs are register-driven; there is no combinational path from inputs to `out` or `out_valid`.

## Structure
- Package `iccad_lane_pkg`: `MODE_FEEDBACK = 1'b0`, `MODE_BYPASS = 1'b1`, FSM state enum `{S_FILL, S_RUN}`, and function `lat(depth) = depth+1`.
- Sub-module `iccad_delay_line` (params `WIDTH`, `DEPTH`; ports clock, reset, enable, clear, d, q) implements the `stg` chain. Instantiated once; its clear input is the flush.
- The top level holds the lane logic, `mode_q`, the counter and the FSM.

## Test plan
- Reset: assert `iccad_rst` 2 cycles with `en=1`, inputs `4'hF` → `out=4'h0`, `out_valid=0`, `mode_q=FEEDBACK` (WIDTH=4, DEPTH=2 throughout).
- BYPASS fill: `mode=1` (flush edge first), then `en=1`, `inp1=4'b1010`, `inp2=4'b1100` held → `out=4'b1000` and `out_valid=1` after 3rd enabled edge, not earlier.
- FEEDBACK toggle: `mode=0`, `inp1=inp2=4'hF` held, `en=1` → `fq` = F,0,F,0…; `out` = F,0,F,0… starting at 3rd edge, `out_valid=1` from 3rd edge.
- Stall: in RUN, drive `en=0` 4 cycles while changing inputs and `mode` → `out`, `out_valid` frozen; on re-enable the pending mode change flushes (`out=0`, `out_valid=0`), with valid back after 3 enabled edges.
- Reset mid-run: in RUN with `out=4'hF`, pulse `iccad_rst` 1 cycle → next cycle `out=0`, `out_valid=0`; refill takes 3 enabled edges.
- DEPTH=1, WIDTH=1 build: inputs `1,1` in BYPASS → `out=1`, `out_valid=1` after 2nd enabled edge.
